// File: rtl/hazard_control_pkg.sv
// Shared constants, FSM encoding and register-hit helper for the hazard unit.
package hazard_control_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned FWD_SEL_W = 2;
    localparam int unsigned REM_W   = 2;
    localparam int unsigned CNT_W   = 32;

    localparam logic [FWD_SEL_W-1:0] FWD_RF = 2'b00;
    localparam logic [FWD_SEL_W-1:0] FWD_W  = 2'b01;
    localparam logic [FWD_SEL_W-1:0] FWD_M  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Register zero is hardwired, so it never produces a dependency.
    function automatic logic reg_hit(input logic [REG_W-1:0] r, input logic [REG_W-1:0] s);
        return (r != '0) && (r == s);
    endfunction

endpackage

// File: rtl/hazard_control_forward_select.sv
// Execute-stage forwarding mux select for one source operand; M beats W.
module forward_select
    import hazard_control_pkg::*;
(
    input  logic [REG_W-1:0]     src,
    input  logic                 reg_write_m,
    input  logic [REG_W-1:0]     write_reg_m,
    input  logic                 reg_write_w,
    input  logic [REG_W-1:0]     write_reg_w,
    output logic [FWD_SEL_W-1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (reg_write_m && reg_hit(write_reg_m, src)) begin
            fwd = FWD_M;
        end else if (reg_write_w && reg_hit(write_reg_w, src)) begin
            fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard unit: stall/flush FSM plus forwarding selects.
// Optional stall-cause counters are built when HAZARD_CONTROL_PERF_EN is defined.
module hazard_control
    import hazard_control_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [REG_W-1:0]     RsD,
    input  logic [REG_W-1:0]     RtD,
    input  logic                 UsesRtD,
    input  logic                 BranchD,
    input  logic                 BranchTakenD,
    input  logic [REG_W-1:0]     RsE,
    input  logic [REG_W-1:0]     RtE,
    input  logic                 MemReadE,
    input  logic                 RegWriteE,
    input  logic [REG_W-1:0]     WriteRegE,
    input  logic                 MemReadM,
    input  logic                 RegWriteM,
    input  logic [REG_W-1:0]     WriteRegM,
    input  logic                 RegWriteW,
    input  logic [REG_W-1:0]     WriteRegW,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushE,
    output logic                 FlushD,
    output logic [FWD_SEL_W-1:0] ForwardAE,
    output logic [FWD_SEL_W-1:0] ForwardBE,
    output logic                 ForwardAD,
    output logic                 ForwardBD
`ifdef HAZARD_CONTROL_PERF_EN
    ,
    output logic [CNT_W-1:0]     LoadStallCnt,
    output logic [CNT_W-1:0]     BranchStallCnt
`endif
);

    state_t           state;
    state_t           state_next;
    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_next;
    logic             stall;
    logic             hit_e;
    logic             hit_m;
    logic             load_use;
    logic             branch_e;
    logic             branch_m;
    logic             any_hazard;
    logic             combined;

    // Decode-stage dependencies; Rt only matters when the instruction reads it.
    assign hit_e = reg_hit(WriteRegE, RsD) || (UsesRtD && reg_hit(WriteRegE, RtD));
    assign hit_m = reg_hit(WriteRegM, RsD) || (UsesRtD && reg_hit(WriteRegM, RtD));

    assign load_use   = MemReadE && hit_e;
    assign branch_e   = BranchD && RegWriteE && !MemReadE && hit_e;
    assign branch_m   = BranchD && MemReadM && hit_m;
    assign any_hazard = load_use || branch_e || branch_m;
    assign combined   = load_use && BranchD;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
        end
    end

    // A load feeding a branch needs two bubbles; everything else needs one.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = any_hazard;
                if (combined) begin
                    state_next = HOLD;
                    rem_next   = REM_W'(1);
                end
            end
            HOLD: begin
                stall    = 1'b1;
                rem_next = rem - REM_W'(1);
                if (rem <= REM_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                rem_next   = '0;
            end
        endcase
    end

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    assign FlushD = BranchTakenD && !stall;

    assign ForwardAD = RegWriteM && reg_hit(WriteRegM, RsD);
    assign ForwardBD = RegWriteM && reg_hit(WriteRegM, RtD);

    forward_select u_fwd_a (
        .src         (RsE),
        .reg_write_m (RegWriteM),
        .write_reg_m (WriteRegM),
        .reg_write_w (RegWriteW),
        .write_reg_w (WriteRegW),
        .fwd         (ForwardAE)
    );

    forward_select u_fwd_b (
        .src         (RtE),
        .reg_write_m (RegWriteM),
        .write_reg_m (WriteRegM),
        .reg_write_w (RegWriteW),
        .write_reg_w (WriteRegW),
        .fwd         (ForwardBE)
    );

`ifdef HAZARD_CONTROL_PERF_EN
    // Two-cycle load-into-branch stalls are charged to the branch counter.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            LoadStallCnt   <= '0;
            BranchStallCnt <= '0;
        end else if (stall) begin
            if ((state == HOLD) || combined) begin
                BranchStallCnt <= BranchStallCnt + CNT_W'(1);
            end else if (load_use) begin
                LoadStallCnt <= LoadStallCnt + CNT_W'(1);
            end else begin
                BranchStallCnt <= BranchStallCnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: vector table plus multi-cycle sequences.
module tb_hazard_control;

    typedef struct packed {
        logic [4:0] rsd;
        logic [4:0] rtd;
        logic       uses_rt;
        logic       branch;
        logic       taken;
        logic [4:0] rse;
        logic [4:0] rte;
        logic       memread_e;
        logic       regwrite_e;
        logic [4:0] wreg_e;
        logic       memread_m;
        logic       regwrite_m;
        logic [4:0] wreg_m;
        logic       regwrite_w;
        logic [4:0] wreg_w;
    } in_t;

    // cause: 0 none, 1 load stall, 2 branch stall
    typedef struct packed {
        logic       stall;
        logic       flushd;
        logic [1:0] fae;
        logic [1:0] fbe;
        logic       fad;
        logic       fbd;
        logic [1:0] cause;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t ex;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       UsesRtD, BranchD, BranchTakenD, MemReadE, RegWriteE;
    logic       MemReadM, RegWriteM, RegWriteW;
    logic       StallF, StallD, FlushE, FlushD, ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_CONTROL_PERF_EN
    logic [31:0] LoadStallCnt, BranchStallCnt;
`endif

    int   nchecks = 0;
    int   nerr    = 0;
    int   exp_ld  = 0;
    int   exp_br  = 0;
    exp_t sb[$];
    vec_t tbl[$];

    hazard_control dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .RsD          (RsD),
        .RtD          (RtD),
        .UsesRtD      (UsesRtD),
        .BranchD      (BranchD),
        .BranchTakenD (BranchTakenD),
        .RsE          (RsE),
        .RtE          (RtE),
        .MemReadE     (MemReadE),
        .RegWriteE    (RegWriteE),
        .WriteRegE    (WriteRegE),
        .MemReadM     (MemReadM),
        .RegWriteM    (RegWriteM),
        .WriteRegM    (WriteRegM),
        .RegWriteW    (RegWriteW),
        .WriteRegW    (WriteRegW),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushE       (FlushE),
        .FlushD       (FlushD),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .ForwardAD    (ForwardAD),
        .ForwardBD    (ForwardBD)
`ifdef HAZARD_CONTROL_PERF_EN
        ,
        .LoadStallCnt   (LoadStallCnt),
        .BranchStallCnt (BranchStallCnt)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t i);
        RsD = i.rsd; RtD = i.rtd; UsesRtD = i.uses_rt; BranchD = i.branch;
        BranchTakenD = i.taken; RsE = i.rse; RtE = i.rte; MemReadE = i.memread_e;
        RegWriteE = i.regwrite_e; WriteRegE = i.wreg_e; MemReadM = i.memread_m;
        RegWriteM = i.regwrite_m; WriteRegM = i.wreg_m; RegWriteW = i.regwrite_w;
        WriteRegW = i.wreg_w;
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            nchecks++;
            nerr++;
            $display("FAIL scoreboard: empty at %0t", $time);
            return;
        end
        e = sb.pop_front();
        if (!Rst) begin
            exp_ld = 0;
            exp_br = 0;
        end
        chk("StallF", 32'(StallF), 32'(e.stall));
        chk("StallD", 32'(StallD), 32'(e.stall));
        chk("FlushE", 32'(FlushE), 32'(e.stall));
        chk("FlushD", 32'(FlushD), 32'(e.flushd));
        chk("ForwardAE", 32'(ForwardAE), 32'(e.fae));
        chk("ForwardBE", 32'(ForwardBE), 32'(e.fbe));
        chk("ForwardAD", 32'(ForwardAD), 32'(e.fad));
        chk("ForwardBD", 32'(ForwardBD), 32'(e.fbd));
`ifdef HAZARD_CONTROL_PERF_EN
        chk("LoadStallCnt", LoadStallCnt, 32'(exp_ld));
        chk("BranchStallCnt", BranchStallCnt, 32'(exp_br));
`endif
        // Counters reflect this cycle only after the next posedge.
        if (Rst && e.stall) begin
            if (e.cause == 2'd1) exp_ld++;
            else exp_br++;
        end
    endtask

    // One pipeline cycle: drive just after posedge, sample at negedge.
    task automatic step(input logic r, input in_t i, input exp_t e);
        @(posedge Clk);
        #1;
        Rst = r;
        drive(i);
        sb.push_back(e);
        @(negedge Clk);
        check_out();
    endtask

    function automatic exp_t mk(input logic stall, input logic fd, input logic [1:0] fae,
                                input logic [1:0] fbe, input logic fad, input logic fbd,
                                input logic [1:0] cause);
        exp_t e;
        e.stall = stall; e.flushd = fd; e.fae = fae; e.fbe = fbe;
        e.fad = fad; e.fbd = fbd; e.cause = cause;
        return e;
    endfunction

    task automatic add(input in_t i, input exp_t e);
        vec_t v;
        v.in = i;
        v.ex = e;
        tbl.push_back(v);
    endtask

    in_t  t;
    in_t  z;
    exp_t e0;

    initial begin
        z  = '0;
        e0 = mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'd0);
        Rst = 1'b0;
        drive(z);

        // Single-cycle vectors, all evaluated from IDLE.
        add(z, e0);
        t = z; t.memread_e = 1; t.wreg_e = 8; t.rsd = 8;
        add(t, mk(1, 0, 2'b00, 2'b00, 0, 0, 2'd1));
        t = z; t.memread_e = 1; t.wreg_e = 8; t.rtd = 8;
        add(t, e0);
        t.uses_rt = 1;
        add(t, mk(1, 0, 2'b00, 2'b00, 0, 0, 2'd1));
        t = z; t.memread_e = 1; t.regwrite_m = 1;
        add(t, e0);
        t = z; t.branch = 1; t.regwrite_e = 1; t.wreg_e = 3; t.rsd = 3;
        add(t, mk(1, 0, 2'b00, 2'b00, 0, 0, 2'd2));
        t.wreg_e = 4;
        add(t, e0);
        t = z; t.branch = 1; t.wreg_e = 3; t.rsd = 3;
        add(t, e0);
        t = z; t.branch = 1; t.memread_m = 1; t.wreg_m = 6; t.rtd = 6; t.uses_rt = 1;
        add(t, mk(1, 0, 2'b00, 2'b00, 0, 0, 2'd2));
        t = z; t.memread_m = 1; t.wreg_m = 6; t.rsd = 6;
        add(t, e0);
        t = z; t.branch = 1; t.regwrite_e = 1; t.wreg_e = 9; t.rtd = 9;
        add(t, e0);
        t = z; t.branch = 1; t.taken = 1;
        add(t, mk(0, 1, 2'b00, 2'b00, 0, 0, 2'd0));
        t = z; t.regwrite_m = 1; t.wreg_m = 5; t.regwrite_w = 1; t.wreg_w = 5;
        t.rte = 5; t.rsd = 5; t.rtd = 5;
        add(t, mk(0, 0, 2'b00, 2'b10, 1, 1, 2'd0));
        t = z; t.regwrite_w = 1; t.wreg_w = 5; t.rse = 5; t.rte = 5;
        add(t, mk(0, 0, 2'b01, 2'b01, 0, 0, 2'd0));
        t = z; t.regwrite_m = 1; t.wreg_m = 7; t.rse = 7; t.regwrite_w = 1;
        t.wreg_w = 7; t.rte = 7;
        add(t, mk(0, 0, 2'b10, 2'b10, 0, 0, 2'd0));
        t = z; t.regwrite_w = 1;
        add(t, e0);
        t = z; t.regwrite_m = 1; t.wreg_m = 12; t.rse = 12; t.rte = 3;
        t.regwrite_w = 1; t.wreg_w = 3;
        add(t, mk(0, 0, 2'b10, 2'b01, 0, 0, 2'd0));

        // Reset state, then release reset away from the clock edge.
        step(1'b0, z, e0);
        step(1'b1, z, e0);

        foreach (tbl[k]) step(1'b1, tbl[k].in, tbl[k].ex);

        // Load-use: one bubble, then clear once E is flushed.
        t = z; t.memread_e = 1; t.wreg_e = 8; t.rsd = 8;
        step(1'b1, t, mk(1, 0, 2'b00, 2'b00, 0, 0, 2'd1));
        step(1'b1, z, e0);

        // Load feeding a branch: two bubbles even after the inputs change.
        t = z; t.memread_e = 1; t.wreg_e = 9; t.branch = 1; t.rtd = 9; t.uses_rt = 1;
        step(1'b1, t, mk(1, 0, 2'b00, 2'b00, 0, 0, 2'd2));
        t = z; t.taken = 1; t.regwrite_m = 1; t.wreg_m = 4; t.rse = 4;
        step(1'b1, t, mk(1, 0, 2'b10, 2'b00, 0, 0, 2'd2));
        t = z; t.taken = 1;
        step(1'b1, t, mk(0, 1, 2'b00, 2'b00, 0, 0, 2'd0));
        step(1'b1, z, e0);

        // Taken branch coinciding with a stall: the stall wins.
        t = z; t.taken = 1; t.memread_e = 1; t.wreg_e = 8; t.rsd = 8;
        step(1'b1, t, mk(1, 0, 2'b00, 2'b00, 0, 0, 2'd1));
        t = z; t.taken = 1;
        step(1'b1, t, mk(0, 1, 2'b00, 2'b00, 0, 0, 2'd0));

        // Reset in the middle of the two-cycle hold.
        t = z; t.memread_e = 1; t.wreg_e = 9; t.branch = 1; t.rsd = 9;
        step(1'b1, t, mk(1, 0, 2'b00, 2'b00, 0, 0, 2'd2));
        step(1'b0, z, e0);
        t = z; t.memread_e = 1; t.wreg_e = 8; t.rsd = 8;
        step(1'b0, t, mk(1, 0, 2'b00, 2'b00, 0, 0, 2'd1));
        step(1'b0, z, e0);
        step(1'b1, z, e0);
        t = z; t.memread_e = 1; t.wreg_e = 9; t.branch = 1; t.rsd = 9;
        step(1'b1, t, mk(1, 0, 2'b00, 2'b00, 0, 0, 2'd2));
        step(1'b1, z, mk(1, 0, 2'b00, 2'b00, 0, 0, 2'd2));
        step(1'b1, z, e0);
        step(1'b1, z, e0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 SHALL have ports: Clk  in  1  pipeline clock, all state updates on posedge.
REQ-002 SHALL have: Rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have: RsD, RtD  in  5 each  decode-stage source register numbers.
REQ-004 SHALL have: UsesRtD, BranchD, BranchTakenD  in  1 each  decode reads Rt / decode holds branch / branch resolved taken.
REQ-005 SHALL have: RsE, RtE  in  5 each; MemReadE, RegWriteE  in  1 each; WriteRegE  in  5; these are the ID/EX register outputs.
REQ-006 SHALL have: MemReadM, RegWriteM  in  1 each; WriteRegM  in  5; RegWriteW  in  1; WriteRegW  in  5.
REQ-007 SHALL have: StallF, StallD, FlushE, FlushD  out  1 each  pipeline control.
REQ-008 SHALL have: ForwardAE, ForwardBE  out  2 each  (00 regfile, 01 from W, 10 from M); ForwardAD, ForwardBD  out  1 each  (1 = from M).

Function
REQ-009 A hit on source S by register R SHALL require R != 0 and R == S; Rt hits in decode count only when UsesRtD=1.
REQ-010 LoadUse SHALL be MemReadE=1 with WriteRegE hitting RsD or RtD.
REQ-011 BranchE SHALL be BranchD=1 with RegWriteE=1, MemReadE=0 and WriteRegE hitting RsD or RtD; BranchM SHALL be BranchD=1 with MemReadM=1 and WriteRegM hitting.
REQ-012 Stall FSM SHALL have states IDLE and HOLD, plus a 2-bit remaining-cycles counter Rem.
REQ-013 In IDLE: LoadUse and BranchD both 1 SHALL give 2 stall cycles (go HOLD, Rem=1); any other single detected hazard SHALL give 1 cycle (stay IDLE).
REQ-014 In HOLD, Rem SHALL decrement each cycle; reaching 0 SHALL return to IDLE; hazard inputs SHALL be ignored while in HOLD.
REQ-015 StallF = StallD = FlushE SHALL equal (IDLE and any hazard) or (state HOLD); this is combinational, 0-cycle latency.
REQ-016 FlushD SHALL equal BranchTakenD and not StallD; when a stall and a taken branch coincide, the stall wins.
REQ-017 ForwardAE SHALL be 10 when RegWriteM=1 and WriteRegM hits RsE; else 01 when RegWriteW=1 and WriteRegW hits RsE; else 00. ForwardBE SHALL use the same rule against RtE.
REQ-018 ForwardAD/BD SHALL be 1 when RegWriteM=1 and WriteRegM hits RsD/RtD (no UsesRtD gating).
REQ-019 Forwarding outputs SHALL be purely combinational and independent of the FSM.

Reset
REQ-020 Asserting Rst (low) SHALL force IDLE, Rem=0 and all counters to 0 immediately, including in the middle of HOLD.
REQ-021 While in reset, stall outputs SHALL still follow REQ-015 from IDLE.
REQ-022 The first posedge after Rst deasserts SHALL evaluate from IDLE.

Configuration
REQ-023 Macro HAZARD_CONTROL_PERF_EN defined SHALL add outputs LoadStallCnt and BranchStallCnt (out, 32 each).
REQ-024 Each counter SHALL increment once per stall cycle attributed to its cause; a 2-cycle combined stall SHALL count under BranchStallCnt.
REQ-025 Counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-026 Without the macro, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 A shared package SHALL hold the forwarding select constants (FWD_RF=00, FWD_W=01, FWD_M=10) and the FSM state encoding.
REQ-028 One sub-module, forward_select, SHALL implement REQ-017 and SHALL be instantiated twice (A and B).
REQ-029 Target size SHALL be 120-400 lines of RTL.

Verification
REQ-030 Load-use: MemReadE=1, WriteRegE=8, RsD=8 -> StallF/StallD/FlushE = 1 for exactly 1 cycle, then 0.
REQ-031 Combined: MemReadE=1, WriteRegE=9, BranchD=1, RtD=9, UsesRtD=1 -> stall for 2 cycles while the inputs are changed in cycle 2, then 0.
REQ-032 Register zero: RegWriteM=1, WriteRegM=0, RsE=0 -> ForwardAE=00; MemReadE=1, WriteRegE=0, RsD=0 -> no stall.
REQ-033 Priority: RegWriteM=1 and RegWriteW=1, both WriteReg=5, RtE=5 -> ForwardBE=10; with RegWriteM=0 -> 01.
REQ-034 Reset mid-HOLD: drive Rst low during cycle 1 of a 2-cycle stall -> state IDLE, stall outputs 0, counters 0 (with HAZARD_CONTROL_PERF_EN defined).
REQ-035 Flush vs stall: BranchTakenD=1 with LoadUse -> FlushD=0 and StallD=1; the next cycle, with no hazard -> FlushD=1.
